// File: rtl/ident_match_pkg.sv
// Shared types and sizing helpers for the identity-match table scanner.
package ident_match_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_SCAN = SCAN;
  localparam logic [1:0] ST_DONE = DONE;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  function automatic int idx_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/ident_cmp.sv
// Combinational WIDTH-bit identity comparator with active-low enable and match.
module ident_cmp #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en_n,
  output logic             match_n
);

  assign match_n = ~(~en_n & (a == b));

endmodule

// File: rtl/ident_match_scanner.sv
// Sequential key search over a DEPTH-entry tagged table using one shared comparator.
// Optional MATCH_COUNT_EN: full scan with a count of matching entries on rsp_count.
module ident_match_scanner
  import ident_match_pkg::*;
#(
  parameter int  WIDTH = DEF_WIDTH,
  parameter int  DEPTH = DEF_DEPTH,
  localparam int IDXW  = idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_all,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_key,
  output logic             req_ready,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [IDXW-1:0]  rsp_index,
  input  logic             rsp_ready
`ifdef MATCH_COUNT_EN
  ,
  output logic [IDXW:0]    rsp_count
`endif
);

  logic [1:0]       state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] key;
  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             cmp_en_n;
  logic             cmp_match_n;
  logic             entry_hit;
  logic             last_idx;

  // NOTE: table data has no reset; only the valid bits decide whether an entry exists.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // clr_all outranks a same-cycle write's valid set; the data write still lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          valid <= '0;
    else if (clr_all) valid <= '0;
    else if (wr_en)   valid[wr_addr] <= 1'b1;
  end

  assign cmp_en_n = ~valid[idx];

  ident_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a       (mem[idx]),
    .b       (key),
    .en_n    (cmp_en_n),
    .match_n (cmp_match_n)
  );

  assign entry_hit = ~cmp_match_n;
  assign last_idx  = (idx == IDXW'(DEPTH - 1));
  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_DONE);

`ifdef MATCH_COUNT_EN
  logic            scan_end;
  logic            hit_acc;
  logic [IDXW-1:0] idx_acc;
  logic [IDXW:0]   cnt_acc;

  // The scan always covers every entry, then spends one tally cycle publishing the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      key       <= '0;
      idx       <= '0;
      rsp_hit   <= 1'b0;
      rsp_index <= '0;
      rsp_count <= '0;
      scan_end  <= 1'b0;
      hit_acc   <= 1'b0;
      idx_acc   <= '0;
      cnt_acc   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            key      <= req_key;
            idx      <= '0;
            scan_end <= 1'b0;
            hit_acc  <= 1'b0;
            idx_acc  <= '0;
            cnt_acc  <= '0;
            state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (scan_end) begin
            rsp_hit   <= hit_acc;
            rsp_index <= idx_acc;
            rsp_count <= cnt_acc;
            scan_end  <= 1'b0;
            state     <= ST_DONE;
          end else begin
            if (entry_hit) begin
              cnt_acc <= cnt_acc + 1'b1;
              if (!hit_acc) begin
                hit_acc <= 1'b1;
                idx_acc <= idx;
              end
            end
            if (last_idx) scan_end <= 1'b1;
            else          idx      <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`else
  // NOTE: all state updates use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      key       <= '0;
      idx       <= '0;
      rsp_hit   <= 1'b0;
      rsp_index <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            key   <= req_key;
            idx   <= '0;
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (entry_hit) begin
            rsp_hit   <= 1'b1;
            rsp_index <= idx;
            state     <= ST_DONE;
          end else if (last_idx) begin
            rsp_hit   <= 1'b0;
            rsp_index <= '0;
            state     <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_ident_match_scanner.sv
// Directed self-checking bench for ident_match_scanner (both MATCH_COUNT_EN builds).
module tb_ident_match_scanner;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int IDXW  = 4;
  localparam int MAX_WAIT = 40;

`ifdef MATCH_COUNT_EN
  localparam bit CNT_MODE = 1'b1;
`else
  localparam bit CNT_MODE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [IDXW-1:0]  wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             clr_all;
  logic             req_valid;
  logic [WIDTH-1:0] req_key;
  logic             req_ready;
  logic             rsp_valid;
  logic             rsp_hit;
  logic [IDXW-1:0]  rsp_index;
  logic             rsp_ready;
`ifdef MATCH_COUNT_EN
  logic [IDXW:0]    rsp_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  ident_match_scanner #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clr_all   (clr_all),
    .req_valid (req_valid),
    .req_key   (req_key),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_hit   (rsp_hit),
    .rsp_index (rsp_index),
    .rsp_ready (rsp_ready)
`ifdef MATCH_COUNT_EN
    ,
    .rsp_count (rsp_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Edges after acceptance until rsp_valid is seen high.
  function automatic int hit_lat(input int k);
    return CNT_MODE ? DEPTH + 1 : k + 1;
  endfunction

  function automatic int miss_lat();
    return CNT_MODE ? DEPTH + 1 : DEPTH;
  endfunction

  // All tasks start and finish at a falling edge.
  task automatic write_entry(input logic [IDXW-1:0] a, input logic [WIDTH-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic clear_table();
    clr_all = 1'b1;
    @(negedge clk);
    clr_all = 1'b0;
  endtask

  task automatic request(input string tag, input logic [WIDTH-1:0] k,
                         input int exp_lat, input logic exp_hit,
                         input logic [IDXW-1:0] exp_idx, input int exp_cnt,
                         input int wr_at, input logic [IDXW-1:0] wa,
                         input logic [WIDTH-1:0] wd, input bit release_rsp);
    int lat;
    lat = 0;
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_key = k;
    @(negedge clk);
    req_valid = 1'b0;
    for (int n = 1; n <= MAX_WAIT; n++) begin
      if (wr_at == n - 1) begin
        wr_en = 1'b1; wr_addr = wa; wr_data = wd;
      end
      @(negedge clk);
      wr_en = 1'b0;
      if (rsp_valid) begin
        lat = n;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_hit"}, 32'(rsp_hit), 32'(exp_hit));
    check({tag, "_index"}, 32'(rsp_index), 32'(exp_idx));
`ifdef MATCH_COUNT_EN
    check({tag, "_count"}, 32'(rsp_count), 32'(exp_cnt));
`else
    if (exp_cnt < 0) $display("note: negative count for %s", tag);
`endif
    if (release_rsp) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
      check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr_all = 1'b0;
    req_valid = 1'b0; req_key = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_hit", 32'(rsp_hit), 32'd0);
    check("reset_rsp_index", 32'(rsp_index), 32'd0);
`ifdef MATCH_COUNT_EN
    check("reset_rsp_count", 32'(rsp_count), 32'd0);
`endif
    @(negedge clk);

    // 1: two equal entries, lowest index wins
    write_entry(4'd3, 8'hA5);
    write_entry(4'd9, 8'hA5);
    request("t1", 8'hA5, hit_lat(3), 1'b1, 4'd3, 2, -1, '0, '0, 1'b1);

    // 2: miss, response held while consumer stalls
    request("t2", 8'h3C, miss_lat(), 1'b0, 4'd0, 0, -1, '0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold_valid", 32'(rsp_valid), 32'd1);
      check("t2_hold_hit", 32'(rsp_hit), 32'd0);
      check("t2_hold_index", 32'(rsp_index), 32'd0);
      check("t2_hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("t2_rsp_drop", 32'(rsp_valid), 32'd0);

    // 3: matching data in an invalidated entry is ignored
    write_entry(4'd0, 8'h00);
    clear_table();
    request("t3", 8'h00, miss_lat(), 1'b0, 4'd0, 0, -1, '0, '0, 1'b1);

    // 4a: write ahead of the scan pointer is seen
    request("t4a", 8'h5A, hit_lat(5), 1'b1, 4'd5, 1, 2, 4'd5, 8'h5A, 1'b1);
    // 4b: write landing on the compare edge of the same entry is not seen
    request("t4b", 8'h6B, miss_lat(), 1'b0, 4'd0, 0, 2, 4'd2, 8'h6B, 1'b1);
    request("t4c", 8'h6B, hit_lat(2), 1'b1, 4'd2, 1, -1, '0, '0, 1'b1);

    // 5: reset mid-scan at idx 7
    check("t5_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_key = 8'hEE;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("t5_busy", 32'(req_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5_rst_rsp_hit", 32'(rsp_hit), 32'd0);
    check("t5_rst_rsp_index", 32'(rsp_index), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_rel_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    request("t5_valid_cleared", 8'h6B, miss_lat(), 1'b0, 4'd0, 0, -1, '0, '0, 1'b1);
    write_entry(4'd0, 8'h11);
    request("t5_idx0", 8'h11, hit_lat(0), 1'b1, 4'd0, 1, -1, '0, '0, 1'b1);

    // clr_all beats a same-cycle write
    clr_all = 1'b1; wr_en = 1'b1; wr_addr = 4'd6; wr_data = 8'h22;
    @(negedge clk);
    clr_all = 1'b0; wr_en = 1'b0;
    request("clr_vs_wr", 8'h22, miss_lat(), 1'b0, 4'd0, 0, -1, '0, '0, 1'b1);

    // 6: three matches, lowest index reported
    write_entry(4'd1, 8'h77);
    write_entry(4'd4, 8'h77);
    write_entry(4'd15, 8'h77);
    request("t6", 8'h77, hit_lat(1), 1'b1, 4'd1, 3, -1, '0, '0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
